// File: rtl/hbconsole_mux.sv
// Splits the UART rx byte stream by bit 7 into hexbus and console streams, and
// merges hexbus/console tx bytes into one UART tx stream. Optional: HBCONSOLE_FAIR_EN.
module hbconsole_mux #(
    parameter int unsigned MAXBURST = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_stb,
    input  logic [7:0] i_rx_data,
    output logic       o_hb_rx_stb,
    output logic [6:0] o_hb_rx_data,
    output logic       o_con_rx_stb,
    output logic [6:0] o_con_rx_data,
    input  logic       i_hb_tx_stb,
    input  logic [6:0] i_hb_tx_data,
    output logic       o_hb_tx_busy,
    input  logic       i_con_tx_stb,
    input  logic [6:0] i_con_tx_data,
    output logic       o_con_tx_busy,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy
);

    localparam int unsigned DW = 8;

    if (MAXBURST < 1 || MAXBURST > 255) begin : g_bad_maxburst
        $error("hbconsole_mux: MAXBURST must be in 1..255");
    end

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          open_c;
    logic          gnt_hb_c;
    logic          gnt_con_c;

    // RX demux: one-cycle registered strobes, payload loaded only for the owning side
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hb_rx_stb   <= 1'b0;
            o_hb_rx_data  <= 7'd0;
            o_con_rx_stb  <= 1'b0;
            o_con_rx_data <= 7'd0;
        end else begin
            o_hb_rx_stb  <= i_rx_stb & i_rx_data[7];
            o_con_rx_stb <= i_rx_stb & ~i_rx_data[7];
            if (i_rx_stb & i_rx_data[7]) o_hb_rx_data <= i_rx_data[6:0];
            if (i_rx_stb & ~i_rx_data[7]) o_con_rx_data <= i_rx_data[6:0];
        end
    end

`ifdef HBCONSOLE_FAIR_EN
    localparam logic [7:0] BURST_LIM = 8'(MAXBURST);

    logic [7:0] burst_q, burst_d;

    // Console overrides hexbus once the hexbus burst has reached its limit
    always_comb begin
        gnt_hb_c  = i_hb_tx_stb & ~(i_con_tx_stb & (burst_q == BURST_LIM));
        gnt_con_c = i_con_tx_stb & ~gnt_hb_c;
        burst_d   = burst_q;
        if (!i_con_tx_stb || (open_c && gnt_con_c)) begin
            burst_d = 8'd0;
        end else if (open_c && gnt_hb_c && burst_q != BURST_LIM) begin
            burst_d = burst_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) burst_q <= 8'd0;
        else          burst_q <= burst_d;
    end
`else
    always_comb begin
        gnt_hb_c  = i_hb_tx_stb;
        gnt_con_c = i_con_tx_stb & ~i_hb_tx_stb;
    end
`endif

    assign open_c        = (state_q == S_EMPTY) | ~i_tx_busy;
    assign o_hb_tx_busy  = ~(open_c & gnt_hb_c);
    assign o_con_tx_busy = ~(open_c & gnt_con_c);

    // Output register: load and drain may happen in the same cycle
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (open_c && gnt_hb_c) begin
            state_d = S_FULL;
            data_d  = {1'b1, i_hb_tx_data};
        end else if (open_c && gnt_con_c) begin
            state_d = S_FULL;
            data_d  = {1'b0, i_con_tx_data};
        end else if (state_q == S_FULL && !i_tx_busy) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign o_tx_stb  = (state_q == S_FULL);
    assign o_tx_data = data_q;

endmodule

// File: tb/tb_hbconsole_mux.sv
// Scoreboard bench for hbconsole_mux: expected bytes are queued at stimulus time
// and compared by a negedge monitor as the DUT emits them.
module tb_hbconsole_mux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_stb = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       hb_rx_stb, con_rx_stb;
    logic [6:0] hb_rx_data, con_rx_data;
    logic       hb_tx_stb = 1'b0;
    logic [6:0] hb_tx_data = 7'd0;
    logic       hb_tx_busy;
    logic       con_tx_stb = 1'b0;
    logic [6:0] con_tx_data = 7'd0;
    logic       con_tx_busy;
    logic       tx_stb;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [6:0] hb_rx_q[$];
    logic [6:0] con_rx_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    hbconsole_mux #(.MAXBURST(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_stb(rx_stb), .i_rx_data(rx_data),
        .o_hb_rx_stb(hb_rx_stb), .o_hb_rx_data(hb_rx_data),
        .o_con_rx_stb(con_rx_stb), .o_con_rx_data(con_rx_data),
        .i_hb_tx_stb(hb_tx_stb), .i_hb_tx_data(hb_tx_data), .o_hb_tx_busy(hb_tx_busy),
        .i_con_tx_stb(con_tx_stb), .i_con_tx_data(con_tx_data), .o_con_tx_busy(con_tx_busy),
        .o_tx_stb(tx_stb), .o_tx_data(tx_data), .i_tx_busy(tx_busy)
    );

    // Monitor: every emitted byte must match the head of its queue
    always @(negedge clk) begin
        logic [7:0] exp;
        if (hb_rx_stb) begin
            tests++;
            if (hb_rx_q.size() == 0) begin
                fails++; $display("FAIL hb_rx_unexpected got=%h", hb_rx_data);
            end else begin
                exp = {1'b0, hb_rx_q.pop_front()};
                if ({1'b0, hb_rx_data} !== exp) begin
                    fails++; $display("FAIL hb_rx_data got=%h exp=%h", hb_rx_data, exp);
                end
            end
        end
        if (con_rx_stb) begin
            tests++;
            if (con_rx_q.size() == 0) begin
                fails++; $display("FAIL con_rx_unexpected got=%h", con_rx_data);
            end else begin
                exp = {1'b0, con_rx_q.pop_front()};
                if ({1'b0, con_rx_data} !== exp) begin
                    fails++; $display("FAIL con_rx_data got=%h exp=%h", con_rx_data, exp);
                end
            end
        end
        if (tx_stb && !tx_busy) begin
            tests++;
            if (tx_q.size() == 0) begin
                fails++; $display("FAIL tx_unexpected got=%h", tx_data);
            end else begin
                exp = tx_q.pop_front();
                if (tx_data !== exp) begin
                    fails++; $display("FAIL tx_data got=%h exp=%h", tx_data, exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((hb_rx_q.size() + con_rx_q.size() + tx_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        tests++;
        if ((hb_rx_q.size() + con_rx_q.size() + tx_q.size()) != 0) begin
            fails++;
            $display("FAIL %s_drain left=%0d exp=0", name,
                     hb_rx_q.size() + con_rx_q.size() + tx_q.size());
            hb_rx_q.delete(); con_rx_q.delete(); tx_q.delete();
        end
    endtask

    // Holds each source's strobe until the requested number of bytes is accepted
    task automatic run_sources(input int n_hb, input logic [6:0] hb_b, input int n_con,
                               input logic [6:0] con_b, input bit strict_chk);
        int hb_left = n_hb;
        int con_left = n_con;
        int budget = 0;
        bit hb_acc, con_acc;
        step();
        hb_tx_data = hb_b; con_tx_data = con_b;
        hb_tx_stb = (hb_left > 0); con_tx_stb = (con_left > 0);
        while ((hb_left > 0 || con_left > 0) && budget < 100) begin
            @(negedge clk);
            hb_acc  = hb_tx_stb & ~hb_tx_busy;
            con_acc = con_tx_stb & ~con_tx_busy;
            if (strict_chk && con_tx_stb) begin
                tests++;
                if (con_acc && hb_left > 0) begin
                    fails++; $display("FAIL strict_con_busy got=0 exp=1 hb_left=%0d", hb_left);
                end
            end
            step();
            if (hb_acc) hb_left--;
            if (con_acc) con_left--;
            hb_tx_stb = (hb_left > 0); con_tx_stb = (con_left > 0);
            budget++;
        end
        tests++;
        if (hb_left != 0 || con_left != 0) begin
            fails++; $display("FAIL sources_timeout hb_left=%0d con_left=%0d exp=0", hb_left, con_left);
        end
        hb_tx_stb = 1'b0; con_tx_stb = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({tx_stb, hb_rx_stb, con_rx_stb} !== 3'b000 || tx_data !== 8'h00 ||
            hb_rx_data !== 7'h00 || con_rx_data !== 7'h00) begin
            fails++; $display("FAIL reset_outputs got=%b/%h/%h/%h exp=000/00/00/00",
                {tx_stb, hb_rx_stb, con_rx_stb}, tx_data, hb_rx_data, con_rx_data);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({tx_stb, hb_tx_busy, con_tx_busy} !== 3'b011) begin
            fails++; $display("FAIL reset_idle got=%b exp=011", {tx_stb, hb_tx_busy, con_tx_busy});
        end
    endtask

    task automatic test_rx();
        step();
        hb_rx_q.push_back(7'h05); con_rx_q.push_back(7'h41);
        rx_stb = 1'b1; rx_data = 8'h85;
        step();
        rx_data = 8'h41;
        @(negedge clk);
        tests++;
        if ({hb_rx_stb, con_rx_stb} !== 2'b10) begin
            fails++; $display("FAIL rx_t1 got=%b exp=10", {hb_rx_stb, con_rx_stb});
        end
        step();
        rx_stb = 1'b0;
        @(negedge clk);
        tests++;
        if ({hb_rx_stb, con_rx_stb} !== 2'b01) begin
            fails++; $display("FAIL rx_t2 got=%b exp=01", {hb_rx_stb, con_rx_stb});
        end
        @(negedge clk);
        tests++;
        if ({hb_rx_stb, con_rx_stb} !== 2'b00) begin
            fails++; $display("FAIL rx_t3 got=%b exp=00", {hb_rx_stb, con_rx_stb});
        end
        wait_drain("rx", 5);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            step();
            b = 8'($urandom);
            if (i == 0) b[7] = 1'b1;
            if (i == 1) b[7] = 1'b0;
            if (b[7]) hb_rx_q.push_back(b[6:0]);
            else      con_rx_q.push_back(b[6:0]);
            rx_stb = 1'b1; rx_data = b;
        end
        step();
        rx_stb = 1'b0;
        wait_drain("rx_b2b", 10);
    endtask

    task automatic test_con_tx();
        step();
        tx_q.push_back(8'h48);
        con_tx_stb = 1'b1; con_tx_data = 7'h48;
        @(negedge clk);
        tests++;
        if (con_tx_busy !== 1'b0) begin
            fails++; $display("FAIL con_tx_busy got=%b exp=0", con_tx_busy);
        end
        step();
        con_tx_stb = 1'b0;
        @(negedge clk);
        tests++;
        if (tx_stb !== 1'b1 || tx_data !== 8'h48) begin
            fails++; $display("FAIL con_tx_out got=%b/%h exp=1/48", tx_stb, tx_data);
        end
        wait_drain("con_tx", 5);
    endtask

    task automatic test_priority();
`ifdef HBCONSOLE_FAIR_EN
        tx_q.push_back(8'hB0); tx_q.push_back(8'hB0); tx_q.push_back(8'h31);
        tx_q.push_back(8'hB0); tx_q.push_back(8'hB0); tx_q.push_back(8'h31);
        run_sources(4, 7'h30, 2, 7'h31, 1'b0);
`else
        tx_q.push_back(8'hB0); tx_q.push_back(8'hB0); tx_q.push_back(8'hB0);
        tx_q.push_back(8'h31);
        run_sources(3, 7'h30, 1, 7'h31, 1'b1);
`endif
        wait_drain("priority", 10);
    endtask

    task automatic test_busy_hold();
        step();
        tx_busy = 1'b1;
        tx_q.push_back(8'hC1);
        hb_tx_stb = 1'b1; hb_tx_data = 7'h41;
        @(negedge clk);
        tests++;
        if (hb_tx_busy !== 1'b0) begin
            fails++; $display("FAIL hold_load got=%b exp=0", hb_tx_busy);
        end
        step();
        hb_tx_data = 7'h22; con_tx_stb = 1'b1; con_tx_data = 7'h33;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if ({tx_stb, hb_tx_busy, con_tx_busy} !== 3'b111 || tx_data !== 8'hC1) begin
                fails++; $display("FAIL hold_cycle%0d got=%b/%h exp=111/c1", i,
                                  {tx_stb, hb_tx_busy, con_tx_busy}, tx_data);
            end
        end
        step();
        hb_tx_stb = 1'b0; con_tx_stb = 1'b0; tx_busy = 1'b0;
        wait_drain("hold", 5);
    endtask

    task automatic test_reset_mid();
        step();
        tx_busy = 1'b1;
        hb_tx_stb = 1'b1; hb_tx_data = 7'h7F;
        @(negedge clk);
        tests++;
        if (hb_tx_busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_load got=%b exp=0", hb_tx_busy);
        end
        step();
        hb_tx_stb = 1'b0;
        @(negedge clk);
        tests++;
        if (tx_stb !== 1'b1 || tx_data !== 8'hFF) begin
            fails++; $display("FAIL rstmid_full got=%b/%h exp=1/ff", tx_stb, tx_data);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (tx_stb !== 1'b0 || tx_data !== 8'h00) begin
            fails++; $display("FAIL rstmid_async got=%b/%h exp=0/00", tx_stb, tx_data);
        end
        step();
        rst_n = 1'b1; tx_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (tx_stb !== 1'b0) begin
                fails++; $display("FAIL rstmid_ghost%0d got=%b exp=0", i, tx_stb);
            end
        end
`ifdef HBCONSOLE_FAIR_EN
        // Counter must restart from 0: two hexbus grants before the console one
        tx_q.push_back(8'hB0); tx_q.push_back(8'hB0); tx_q.push_back(8'h31);
        run_sources(2, 7'h30, 1, 7'h31, 1'b0);
        wait_drain("rstmid_fair", 10);
`endif
    endtask

    initial begin
        test_reset();
        test_rx();
        test_back_to_back();
        test_con_tx();
        test_priority();
        test_busy_hold();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
